// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter-side types, state encodings and helpers
package arb_pkg;

    localparam int ARB_NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when exactly one bit of v is set; narrower vectors are zero-extended by the caller.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - grant vector encoder: binary index, one-hot check, any-set flag
// Ports:
//   gnt_i        grant vector from the arbiter
//   idx_o        binary index of the set bit (meaningful only when onehot_ok_o)
//   onehot_ok_o  exactly one bit of gnt_i is set
//   any_o        at least one bit of gnt_i is set
module onehot_enc
    import arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] gnt_i,
    output logic [IW-1:0]   idx_o,
    output logic            onehot_ok_o,
    output logic            any_o
);

    assign any_o       = |gnt_i;
    assign onehot_ok_o = is_onehot(32'(gnt_i));

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/arb_burst_mux.sv
// rtl/arb_burst_mux.sv - locks onto the granted master and steers a fixed-length burst to the sink
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   gnt              one-hot grant from the arbiter
//   m_data, m_valid  packed master data (master i at [i*DW +: DW]) and per-master valid
//   m_ready          per-master ready, only the owner bit can be set
//   out_data/out_valid/out_ready  shared output channel
//   done             one-cycle pulse to the owner when its burst completes
//   owner            index of current or last owner
//   busy             high in XFER or DONE
//   err              sticky flag, multi-hot grant seen while idle
module arb_burst_mux
    import arb_pkg::*;
#(
    parameter int NREQ  = ARB_NREQ,
    parameter int DW    = 8,
    parameter int BURST = 4,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW = $clog2(BURST + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    gnt,
    input  logic [NREQ*DW-1:0] m_data,
    input  logic [NREQ-1:0]    m_valid,
    output logic [NREQ-1:0]    m_ready,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NREQ-1:0]    done,
    output logic [IW-1:0]      owner,
    output logic               busy,
    output logic               err
);

    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            err_q, err_d;
    logic            beat;

    logic [IW-1:0]   enc_idx;
    logic            enc_ok;
    logic            enc_any;

    onehot_enc #(.NREQ(NREQ)) u_enc (
        .gnt_i       (gnt),
        .idx_o       (enc_idx),
        .onehot_ok_o (enc_ok),
        .any_o       (enc_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        owner_d   = owner_q;
        err_d     = err_q;
        m_ready   = '0;
        out_data  = '0;
        out_valid = 1'b0;
        done      = '0;
        beat      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    if (enc_ok) begin
                        owner_d = enc_idx;
                        beat_d  = '0;
                        state_d = ST_XFER;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                // Zero-latency pass-through from the latched owner; gnt changes to
                // other masters are ignored, only withdrawal of the owner's grant matters.
                out_data         = m_data[owner_q*DW +: DW];
                out_valid        = m_valid[owner_q];
                m_ready[owner_q] = out_ready;
                beat             = m_valid[owner_q] && out_ready;
                if (beat) begin
                    beat_d = beat_q + 1'b1;
                end
                // Withdrawal wins over completion: an aborted burst never pulses done.
                if (!gnt[owner_q]) begin
                    state_d = ST_IDLE;
                end else if (beat && (beat_q == LAST_BEAT)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done[owner_q] = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign owner = owner_q;
    assign err   = err_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arb_burst_mux.sv
// tb/tb_arb_burst_mux.sv - directed self-checking bench for arb_burst_mux
module tb_arb_burst_mux;

    logic        clk;
    logic        rst;
    logic [3:0]  gnt;
    logic [31:0] m_data;
    logic [3:0]  m_valid;
    logic [3:0]  m_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  done;
    logic [1:0]  owner;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    arb_burst_mux #(.NREQ(4), .DW(8), .BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .gnt       (gnt),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .owner     (owner),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Master i presents (i+1)*16 + k in stimulus step k so a wrong steer or a stale beat is visible.
    function automatic logic [7:0] dval(input int i, input int k);
        return 8'((i + 1) * 16 + k);
    endfunction

    task automatic drive_data(input int k);
        for (int i = 0; i < 4; i++) m_data[i*8 +: 8] = dval(i, k);
    endtask

    task automatic test_reset();
        rst = 1'b1; gnt = 4'b0; m_valid = 4'b0; out_ready = 1'b0; m_data = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({m_ready, out_valid, out_data, done, busy, owner, err} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {m_ready, out_valid, out_data, done, busy, owner, err});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk); gnt = 4'b0001; m_valid = 4'b0001; out_ready = 1'b1; drive_data(0); #1;
        checks++;
        if (busy !== 1'b0 || m_ready !== 4'b0) begin
            failures++; $display("FAIL basic_idle busy=%b m_ready=%b exp busy=0 m_ready=0000", busy, m_ready);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); drive_data(c); #1;
            checks++;
            if ({out_valid, m_ready, done, busy} !== 10'b1_0001_0000_1 || out_data !== dval(0, c)) begin
                failures++;
                $display("FAIL basic_beat%0d v=%b rdy=%b done=%b busy=%b data=%h exp v=1 rdy=0001 done=0000 busy=1 data=%h",
                         c, out_valid, m_ready, done, busy, out_data, dval(0, c));
            end
        end
        @(negedge clk); gnt = 4'b0; #1;
        checks++;
        if ({done, out_valid, m_ready, busy} !== 10'b0001_0_0000_1 || out_data !== 8'h0) begin
            failures++;
            $display("FAIL basic_done done=%b v=%b rdy=%b busy=%b data=%h exp done=0001 v=0 rdy=0000 busy=1 data=00",
                     done, out_valid, m_ready, busy, out_data);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 4'b0) begin
            failures++; $display("FAIL basic_idle_after busy=%b done=%b exp busy=0 done=0000", busy, done);
        end
    endtask

    task automatic test_toggle_ready();
        int beats;
        int dones;
        beats = 0; dones = 0;
        @(negedge clk); gnt = 4'b0100; m_valid = 4'b1111; out_ready = 1'b1; drive_data(0); #1;
        checks++;
        if (m_ready !== 4'b0) begin
            failures++; $display("FAIL toggle_idle_ready got=%b exp=0000", m_ready);
        end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); out_ready = (c % 2 == 1); drive_data(c); #1;
            if (out_valid && out_ready) beats++;
            if (done !== 4'b0) dones++;
            checks++;
            if (m_ready !== (out_ready ? 4'b0100 : 4'b0000) || out_valid !== 1'b1 || out_data !== dval(2, c)) begin
                failures++;
                $display("FAIL toggle_c%0d rdy=%b v=%b data=%h exp rdy=%b v=1 data=%h",
                         c, m_ready, out_valid, out_data, out_ready ? 4'b0100 : 4'b0000, dval(2, c));
            end
        end
        @(negedge clk); gnt = 4'b0; out_ready = 1'b1; #1;
        if (done !== 4'b0) dones++;
        checks++;
        if (done !== 4'b0100 || m_ready !== 4'b0) begin
            failures++; $display("FAIL toggle_done done=%b rdy=%b exp done=0100 rdy=0000", done, m_ready);
        end
        repeat (2) begin
            @(negedge clk); #1;
            if (done !== 4'b0) dones++;
        end
        checks++;
        if (beats !== 4 || dones !== 1) begin
            failures++; $display("FAIL toggle_counts beats=%0d dones=%0d exp beats=4 dones=1", beats, dones);
        end
    endtask

    task automatic test_err();
        @(negedge clk); gnt = 4'b0011; m_valid = 4'b1111; out_ready = 1'b1; #1;
        checks++;
        if (m_ready !== 4'b0 || err !== 1'b0) begin
            failures++; $display("FAIL err_pre rdy=%b err=%b exp rdy=0000 err=0", m_ready, err);
        end
        @(negedge clk); #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || m_ready !== 4'b0 || owner !== 2'd2) begin
            failures++;
            $display("FAIL err_set err=%b busy=%b rdy=%b owner=%0d exp err=1 busy=0 rdy=0000 owner=2", err, busy, m_ready, owner);
        end
        @(negedge clk); gnt = 4'b1000; drive_data(0); #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); drive_data(c); #1;
            checks++;
            if ({out_valid, m_ready, owner, err} !== 8'b1_1000_11_1 || out_data !== dval(3, c)) begin
                failures++;
                $display("FAIL err_burst%0d v=%b rdy=%b owner=%0d err=%b data=%h exp v=1 rdy=1000 owner=3 err=1 data=%h",
                         c, out_valid, m_ready, owner, err, out_data, dval(3, c));
            end
        end
        @(negedge clk); gnt = 4'b0; #1;
        checks++;
        if (done !== 4'b1000 || err !== 1'b1) begin
            failures++; $display("FAIL err_done done=%b err=%b exp done=1000 err=1", done, err);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int dones;
        int beats;
        dones = 0; beats = 0;
        @(negedge clk); gnt = 4'b0010; m_valid = 4'b0010; out_ready = 1'b1; drive_data(0); #1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); drive_data(c);
            if (c == 3) gnt = 4'b0;
            #1;
            checks++;
            if (out_valid !== 1'b1 || m_ready !== 4'b0010 || out_data !== dval(1, c)) begin
                failures++;
                $display("FAIL abort_beat%0d v=%b rdy=%b data=%h exp v=1 rdy=0010 data=%h", c, out_valid, m_ready, out_data, dval(1, c));
            end
        end
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk); #1;
            if (done !== 4'b0) dones++;
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                failures++; $display("FAIL abort_idle%0d busy=%b v=%b exp busy=0 v=0", c, busy, out_valid);
            end
        end
        checks++;
        if (dones !== 0) begin
            failures++; $display("FAIL abort_no_done dones=%0d exp=0", dones);
        end
        @(negedge clk); gnt = 4'b1000; m_valid = 4'b1000; #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); drive_data(c); #1;
            if (out_valid && out_ready && out_data === dval(3, c)) beats++;
        end
        @(negedge clk); gnt = 4'b0; #1;
        checks++;
        if (beats !== 4 || done !== 4'b1000) begin
            failures++; $display("FAIL abort_next beats=%0d done=%b exp beats=4 done=1000", beats, done);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int beats;
        beats = 0;
        @(negedge clk); gnt = 4'b0100; m_valid = 4'b1111; out_ready = 1'b1; #1;
        repeat (2) begin
            @(negedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1 || owner !== 2'd2) begin
            failures++; $display("FAIL rstmid_pre v=%b owner=%0d exp v=1 owner=2", out_valid, owner);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_ready, out_valid, out_data, done, busy, owner, err} !== 21'h0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%h exp=0", {m_ready, out_valid, out_data, done, busy, owner, err});
        end
        gnt = 4'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); gnt = 4'b0001; #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); drive_data(c); #1;
            if (out_valid && m_ready === 4'b0001 && out_data === dval(0, c)) beats++;
        end
        @(negedge clk); gnt = 4'b0; #1;
        checks++;
        if (beats !== 4 || done !== 4'b0001) begin
            failures++; $display("FAIL rstmid_after beats=%0d done=%b exp beats=4 done=0001", beats, done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk); gnt = 4'b0001; m_valid = 4'b1111; out_ready = 1'b1; #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); drive_data(c); #1;
            checks++;
            if (owner !== 2'd0 || out_valid !== 1'b1 || out_data !== dval(0, c)) begin
                failures++;
                $display("FAIL b2b_first%0d owner=%0d v=%b data=%h exp owner=0 v=1 data=%h", c, owner, out_valid, out_data, dval(0, c));
            end
        end
        @(negedge clk); gnt = 4'b0010; #1;
        checks++;
        if (done !== 4'b0001 || out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_done0 done=%b v=%b exp done=0001 v=0", done, out_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || owner !== 2'd0) begin
            failures++; $display("FAIL b2b_gap busy=%b v=%b owner=%0d exp busy=0 v=0 owner=0", busy, out_valid, owner);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); drive_data(c); #1;
            checks++;
            if (owner !== 2'd1 || out_valid !== 1'b1 || m_ready !== 4'b0010 || out_data !== dval(1, c)) begin
                failures++;
                $display("FAIL b2b_second%0d owner=%0d v=%b rdy=%b data=%h exp owner=1 v=1 rdy=0010 data=%h",
                         c, owner, out_valid, m_ready, out_data, dval(1, c));
            end
        end
        @(negedge clk); gnt = 4'b0; #1;
        checks++;
        if (done !== 4'b0010) begin
            failures++; $display("FAIL b2b_done1 done=%b exp=0010", done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_ready();
        test_err();
        test_abort();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
